// File: rtl/booth_mult_seq_if.sv
// Handshake and operand/result bus for the sequential Booth multiplier.
interface booth_mult_seq_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned CW = $clog2(WIDTH + 2);

    logic               start;
    logic               signed_mode;
    logic [WIDTH-1:0]   multiplicand;
    logic [WIDTH-1:0]   multiplier;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] result;
    logic [CW-1:0]      count;

    // Requester side: issues operations and observes the product.
    modport master (
        output start, signed_mode, multiplicand, multiplier,
        input  busy, done, result, count
    );

    // Multiplier side.
    modport slave (
        input  start, signed_mode, multiplicand, multiplier,
        output busy, done, result, count
    );
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential Booth multiplier with start/busy/done handshake and signed/unsigned mode.
// Radix-2 by default; defining BOOTH_RADIX4_EN switches to radix-4 modified Booth
// recoding (two multiplier bits per iteration) with bit-identical results.
module booth_mult_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    booth_mult_seq_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH + 2);

`ifdef BOOTH_RADIX4_EN
    // Operand width must be even so the 2-bit scan lines up with the sign bit.
    localparam int unsigned QW    = (((WIDTH + 2) % 2) == 0) ? (WIDTH + 2) : (WIDTH + 3);
    localparam int unsigned AW    = QW + 1;
    localparam int unsigned SH    = 2;
    localparam int unsigned ITERS = QW / 2;
`else
    localparam int unsigned QW    = WIDTH + 1;
    localparam int unsigned AW    = QW;
    localparam int unsigned SH    = 1;
    localparam int unsigned ITERS = WIDTH + 1;
`endif
    localparam int unsigned VW = AW + QW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [AW-1:0]      a_q, a_d;
    logic [QW-1:0]      q_q, q_d;
    logic [QW-1:0]      m_q, m_d;
    logic               q1_q, q1_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic [AW-1:0]        sum;
    logic signed [VW-1:0] vec;
    logic signed [VW-1:0] vec_sh;
    logic                 ext_m, ext_q;

    // One Booth iteration: recode, add/subtract into A, then arithmetic shift of {A,Q,Q_1}.
    always_comb begin
        sum = a_q;
`ifdef BOOTH_RADIX4_EN
        case ({q_q[1], q_q[0], q1_q})
            3'b001, 3'b010: sum = a_q + {m_q[QW-1], m_q};
            3'b011:         sum = a_q + {m_q, 1'b0};
            3'b100:         sum = a_q + ~{m_q, 1'b0} + AW'(1);
            3'b101, 3'b110: sum = a_q + ~{m_q[QW-1], m_q} + AW'(1);
            default:        sum = a_q;
        endcase
`else
        case ({q_q[0], q1_q})
            2'b01:   sum = a_q + m_q;
            2'b10:   sum = a_q + ~m_q + AW'(1);
            default: sum = a_q;
        endcase
`endif
        vec    = {sum, q_q, q1_q};
        vec_sh = vec >>> SH;
    end

    // Operand extension applied at the accepting edge.
    always_comb begin
        ext_m = bus.signed_mode & bus.multiplicand[WIDTH-1];
        ext_q = bus.signed_mode & bus.multiplier[WIDTH-1];
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        q_d      = q_q;
        m_d      = m_q;
        q1_d     = q1_q;
        count_d  = count_q;
        result_d = result_q;
        done_d   = 1'b0;

        case (state_q)
            S_RUN: begin
                a_d     = vec_sh[VW-1 -: AW];
                q_d     = vec_sh[QW:1];
                q1_d    = vec_sh[0];
                count_d = count_q + CW'(1);
                if (count_q == CW'(ITERS - 1)) begin
                    result_d = vec_sh[2*WIDTH:1];
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end
            end
            default: begin
                if (bus.start) begin
                    m_d     = {{(QW-WIDTH){ext_m}}, bus.multiplicand};
                    q_d     = {{(QW-WIDTH){ext_q}}, bus.multiplier};
                    a_d     = '0;
                    q1_d    = 1'b0;
                    count_d = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase

        busy_d = (state_d == S_RUN);
    end

    // State and datapath registers; synchronous reset aborts any operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            q_q      <= '0;
            m_q      <= '0;
            q1_q     <= 1'b0;
            count_q  <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            q_q      <= q_d;
            m_q      <= m_d;
            q1_q     <= q1_d;
            count_q  <= count_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.count  = count_q;

endmodule
